// File: rtl/maxnet_seq_ctrl_if.sv
// rtl/maxnet_seq_ctrl_if.sv - control/status bundle between the maxnet sequencer and its host/datapath
// master = sequencer side, slave = host/datapath side.
interface maxnet_seq_ctrl_if #(
  parameter int N_CH = 4,
  parameter int IT_W = 8
);
  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic             start;
  logic             abort;
  logic             isfinished;
  logic [IT_W-1:0]  cfg_iter_limit;
  logic             init_w;
  logic             init_x;
  logic             load_sel;
  logic             load_a;
  logic [IDX_W-1:0] ch_idx;
  logic [IT_W-1:0]  iter_cnt;
  logic             busy;
  logic             done;
  logic             timeout;

  modport master (
    input  start, abort, isfinished, cfg_iter_limit,
    output init_w, init_x, load_sel, load_a, ch_idx, iter_cnt, busy, done, timeout
  );

  modport slave (
    output start, abort, isfinished, cfg_iter_limit,
    input  init_w, init_x, load_sel, load_a, ch_idx, iter_cnt, busy, done, timeout
  );
endinterface

// File: rtl/maxnet_seq_ctrl.sv
// rtl/maxnet_seq_ctrl.sv - sequencer stepping a maxnet datapath channel by channel until convergence or limit
// Moore FSM: every output is a decode of the state register or a registered value.
module maxnet_seq_ctrl #(
  parameter int N_CH    = 4,
  parameter int MAC_LAT = 2,
  parameter int IT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  maxnet_seq_ctrl_if.master   bus
);
  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int ST_W  = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [IDX_W-1:0] CH_LAST  = IDX_W'(N_CH - 1);
  localparam logic [ST_W-1:0]  STG_LAST = ST_W'(MAC_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_MULT  = 3'd2,
    S_ADD   = 3'd3,
    S_WB    = 3'd4,
    S_CHECK = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ch_q, ch_d;
  logic [IT_W-1:0]  it_q, it_d;
  logic [ST_W-1:0]  stg_q, stg_d;
  logic [IT_W-1:0]  lim_q, lim_d;
  logic             to_q, to_d;
  logic             ls_q, ls_d;
  logic [IT_W-1:0]  it_next;
  logic             abortable;

  assign it_next   = it_q + 1'b1;
  assign abortable = (state_q == S_INIT) || (state_q == S_MULT) || (state_q == S_ADD) ||
                     (state_q == S_WB) || (state_q == S_CHECK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      it_q    <= '0;
      stg_q   <= '0;
      lim_q   <= '0;
      to_q    <= 1'b0;
      ls_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      it_q    <= it_d;
      stg_q   <= stg_d;
      lim_q   <= lim_d;
      to_q    <= to_d;
      ls_q    <= ls_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    it_d    = it_q;
    stg_d   = stg_q;
    lim_d   = lim_q;
    to_d    = to_q;
    ls_d    = ls_q;

    case (state_q)
      S_IDLE: begin
        ch_d  = '0;
        stg_d = '0;
        ls_d  = 1'b0;
        if (bus.start) state_d = S_INIT;
      end
      S_INIT: begin
        ls_d = 1'b0;
        if (!bus.start) begin
          state_d = S_MULT;
          ch_d    = '0;
          it_d    = '0;
          stg_d   = '0;
          lim_d   = bus.cfg_iter_limit;
          to_d    = 1'b0;
        end
      end
      S_MULT: begin
        if (stg_q == STG_LAST) begin
          state_d = S_ADD;
          stg_d   = '0;
        end else begin
          stg_d = stg_q + 1'b1;
        end
      end
      S_ADD: begin
        state_d = S_WB;
      end
      S_WB: begin
        if (ch_q < CH_LAST) begin
          ch_d    = ch_q + 1'b1;
          state_d = S_MULT;
        end else begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        // Convergence is tested first so it wins over a simultaneous limit hit.
        if (bus.isfinished) begin
          state_d = S_DONE;
          to_d    = 1'b0;
        end else if ((lim_q != '0) && (it_next == lim_q)) begin
          state_d = S_DONE;
          to_d    = 1'b1;
        end else begin
          state_d = S_MULT;
          ch_d    = '0;
          stg_d   = '0;
          ls_d    = 1'b1;
          if (it_q != '1) it_d = it_next;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        ch_d    = '0;
        ls_d    = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        ch_d    = '0;
        stg_d   = '0;
        ls_d    = 1'b0;
      end
    endcase

    if (bus.abort && abortable) begin
      state_d = S_IDLE;
      ch_d    = '0;
      stg_d   = '0;
      to_d    = 1'b0;
      ls_d    = 1'b0;
    end
  end

  assign bus.init_w   = (state_q == S_INIT);
  assign bus.init_x   = (state_q == S_INIT);
  assign bus.load_a   = (state_q == S_WB);
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.load_sel = ls_q;
  assign bus.ch_idx   = ch_q;
  assign bus.iter_cnt = it_q;
  assign bus.timeout  = to_q;
endmodule
